mips_data_mem: RTL and testbench

//  Data-memory responder: the slave end of the core's data port (mem_addr/mem_data_in/mem_write_en out,
//  mem_data_out/mem_excpt back). Accepts one word-addressed request at a time, inserts a configurable

---
 rtl/mips_data_mem.sv | 120 ++++++++++++
 tb/tb_mips_data_mem.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_mem.sv
// Data-memory responder for the core's data port: one word-addressed request at a time,
// a fixed number of wait states, byte-lane masked stores and full-word loads.
module mips_data_mem #(
  parameter logic [31:0] data_start  = 32'h1000_0000,
  parameter int          depth_words = 1024,
  parameter int          wait_states = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_data_in,
  input  logic [3:0]  mem_write_en,
  output logic [31:0] mem_data_out,
  output logic        mem_ready,
  output logic        mem_excpt,
  output logic        busy
);

  localparam int          AW      = (depth_words > 1) ? $clog2(depth_words) : 1;
  localparam logic [29:0] BASE_W  = data_start[31:2];
  localparam logic [30:0] DEPTH_W = 31'(depth_words);
  localparam logic [3:0]  WS      = 4'(wait_states);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [29:0] idx_q;
  logic [31:0] data_q;
  logic [3:0]  mask_q;
  logic [31:0] mem [depth_words];

  logic [29:0] idx_in;
  logic [29:0] cur_idx;
  logic [31:0] cur_data;
  logic [3:0]  cur_mask;
  logic        cur_in_range;
  logic [AW-1:0] word_sel;
  logic        enter_resp;

  // Addresses below data_start wrap to huge indices and so fall out of range.
  assign idx_in = mem_addr - BASE_W;

  // With zero wait states RESP is entered on the accepting edge, so the live
  // inputs stand in for the not-yet-latched request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cur_idx  = idx_q;
    cur_data = data_q;
    cur_mask = mask_q;
    if (state == ST_IDLE) begin
      cur_idx  = idx_in;
      cur_data = mem_data_in;
      cur_mask = mem_write_en;
    end
  end

  assign cur_in_range = {1'b0, cur_idx} < DEPTH_W;
  assign word_sel     = cur_idx[AW-1:0];
  assign enter_resp   = (next_state == ST_RESP);

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_b) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (mem_req) next_state = (WS != 4'd0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt == 4'd1) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Request latch, wait counter and registered response.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt          <= 4'd0;
      idx_q        <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      mem_ready    <= 1'b0;
      mem_excpt    <= 1'b0;
      mem_data_out <= '0;
    end else begin
      if (state == ST_IDLE && mem_req) begin
        idx_q  <= idx_in;
        data_q <= mem_data_in;
        mask_q <= mem_write_en;
        cnt    <= WS;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      mem_ready <= enter_resp;
      mem_excpt <= enter_resp && !cur_in_range;
      if (enter_resp)
        mem_data_out <= (cur_in_range && cur_mask == 4'b0000) ? mem[word_sel] : '0;
    end
  end

  // NOTE: the array has no reset; gating with rst_b keeps a store from landing while reset is held.
  always_ff @(posedge clk) begin
    if (rst_b && enter_resp && cur_in_range) begin
      for (int b = 0; b < 4; b++)
        if (cur_mask[b]) mem[word_sel][8*b +: 8] <= cur_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed and scoreboarded checks of mips_data_mem at wait_states 0..3 (instance index = wait states).
module tb_mips_data_mem;

  localparam logic [29:0] BASE = 30'h0400_0000;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req [4];
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic [31:0] dout [4];
  logic        rdy  [4];
  logic        exc  [4];
  logic        bsy  [4];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [4][1024];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mips_data_mem #(.wait_states(g)) u_dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .mem_req      (req[g]),
      .mem_addr     (addr),
      .mem_data_in  (wdata),
      .mem_write_en (mask),
      .mem_data_out (dout[g]),
      .mem_ready    (rdy[g]),
      .mem_excpt    (exc[g]),
      .busy         (bsy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One full transaction on instance w; inputs are scrambled after accept.
  task automatic txn(input int w, input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                     output logic [31:0] rd, output logic ex);
    int cyc;
    @(negedge clk);
    addr = a; wdata = d; mask = m; req[w] = 1'b1;
    @(posedge clk);
    #1;
    req[w] = 1'b0; addr = ~a; wdata = ~d; mask = ~m;
    cyc = 0; rd = '0; ex = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_c1", 32'(bsy[w]), 32'd1);
      if (rdy[w]) break;
    end
    rd = dout[w];
    ex = exc[w];
    check($sformatf("latency_ws%0d", w), cyc, w + 1);
    @(negedge clk);
    check("ready_pulse", 32'(rdy[w]), 32'd0);
    check("excpt_clear", 32'(exc[w]), 32'd0);
    check("idle_busy", 32'(bsy[w]), 32'd0);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        ex;
    for (int i = 0; i < 4; i++) req[i] = 1'b0;
    addr = '0; wdata = '0; mask = '0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", dout[2], 32'h0);
    check("rst_ready", 32'(rdy[2]), 32'd0);
    check("rst_excpt", 32'(exc[2]), 32'd0);
    check("rst_busy", 32'(bsy[2]), 32'd0);
    rst_b = 1'b1;

    // 1: store then load, wait_states=2
    txn(2, BASE, 32'hDEAD_BEEF, 4'hF, rd, ex);
    check("t1_st_data", rd, 32'h0);
    check("t1_st_excpt", 32'(ex), 32'd0);
    txn(2, BASE, 32'h0, 4'h0, rd, ex);
    check("t1_ld_data", rd, 32'hDEAD_BEEF);
    check("t1_ld_excpt", 32'(ex), 32'd0);

    // 2: byte-lane stores
    txn(2, BASE + 30'd1, 32'h1122_3344, 4'hF, rd, ex);
    txn(2, BASE + 30'd1, 32'h0000_00AA, 4'b0001, rd, ex);
    txn(2, BASE + 30'd1, 32'h0, 4'h0, rd, ex);
    check("t2_lane0", rd, 32'h1122_33AA);
    txn(2, BASE + 30'd1, 32'h0055_0000, 4'b0100, rd, ex);
    txn(2, BASE + 30'd1, 32'h0, 4'h0, rd, ex);
    check("t2_lane2", rd, 32'h1155_33AA);

    // 3: range boundaries
    txn(2, BASE + 30'd1024, 32'h0, 4'h0, rd, ex);
    check("t3_end_excpt", 32'(ex), 32'd1);
    check("t3_end_data", rd, 32'h0);
    txn(2, 30'h03FF_FFFF, 32'h0, 4'h0, rd, ex);
    check("t3_below_excpt", 32'(ex), 32'd1);
    check("t3_below_data", rd, 32'h0);
    txn(2, BASE + 30'd1024, 32'hFFFF_FFFF, 4'hF, rd, ex);
    check("t3_st_excpt", 32'(ex), 32'd1);
    txn(2, BASE, 32'h0, 4'h0, rd, ex);
    check("t3_unchanged", rd, 32'hDEAD_BEEF);
    txn(2, BASE + 30'd1023, 32'h5A5A_1234, 4'hF, rd, ex);
    check("t3_last_excpt", 32'(ex), 32'd0);
    txn(2, BASE + 30'd1023, 32'h0, 4'h0, rd, ex);
    check("t3_last_data", rd, 32'h5A5A_1234);

    // 4: wait_states=0 with mem_req held for four edges
    @(negedge clk);
    addr = BASE + 30'd1024; wdata = '0; mask = '0; req[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("t4_ready_c%0d", k), 32'(rdy[0]), 32'(k % 2));
      check($sformatf("t4_busy_c%0d", k), 32'(bsy[0]), 32'(k % 2));
      check($sformatf("t4_excpt_c%0d", k), 32'(exc[0]), 32'(k % 2));
    end
    req[0] = 1'b0;
    @(negedge clk);
    check("t4_ready_end", 32'(rdy[0]), 32'd0);
    check("t4_busy_end", 32'(bsy[0]), 32'd0);

    // 5: reset during WAIT of a store
    @(negedge clk);
    addr = BASE; wdata = 32'hFFFF_FFFF; mask = 4'hF; req[2] = 1'b1;
    @(posedge clk);
    #1 req[2] = 1'b0;
    @(negedge clk);
    check("t5_busy_wait", 32'(bsy[2]), 32'd1);
    rst_b = 1'b0;
    #1;
    check("t5_busy", 32'(bsy[2]), 32'd0);
    check("t5_ready", 32'(rdy[2]), 32'd0);
    check("t5_excpt", 32'(exc[2]), 32'd0);
    check("t5_dout", dout[2], 32'h0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    txn(2, BASE, 32'h0, 4'h0, rd, ex);
    check("t5_old_word", rd, 32'hDEAD_BEEF);

    // 6: scoreboarded random traffic over a small window plus out-of-range addresses
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 10; i++) begin
        int ix;
        logic [31:0] v;
        ix = (i < 8) ? i : 1014 + i;
        v  = $urandom;
        model[w][ix] = v;
        txn(w, BASE + 30'(ix), v, 4'hF, rd, ex);
      end
    end
    for (int n = 0; n < 200; n++) begin
      int          w, sel, ix;
      logic        inr;
      logic [29:0] a;
      logic [31:0] d, exp_d;
      logic [3:0]  m;
      w   = $urandom_range(0, 3);
      sel = $urandom_range(0, 11);
      d   = $urandom;
      m   = 4'($urandom_range(0, 15));
      inr = 1'b1;
      ix  = 0;
      case (sel)
        8:       ix = 1023;
        9:       begin ix = 1024; inr = 1'b0; end
        10:      inr = 1'b0;
        11:      ix = 1022;
        default: ix = sel;
      endcase
      a = (sel == 10) ? BASE - 30'd1 : BASE + 30'(ix);
      exp_d = '0;
      if (inr) begin
        if (m == 4'b0000) exp_d = model[w][ix];
        else              model[w][ix] = merge(model[w][ix], d, m);
      end
      txn(w, a, d, m, rd, ex);
      check($sformatf("rnd%0d_data", n), rd, exp_d);
      check($sformatf("rnd%0d_excpt", n), 32'(ex), 32'(!inr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
